fp_norm_shift: RTL

Two-stage pipelined significand normalizer for the FP32 datapath. It consumes a 23-bit significand, its biased exponent, and the leading-zero count that a combinational count-leading-zeros block produces for that significand. It left-shifts the significand so the leading one lands at bit 22 and adjusts the exponent to match. When the exponent would go below 1, it clamps to a denormal result; it also flags zero inputs and inconsistent counts. It sits between the FMA/add result stage and the rounder, behind a valid/ready handshake.

---
 rtl/fp_norm_shift.sv | 114 +++++++++++
 1 files changed

// File: rtl/fp_norm_shift.sv
// Two-stage pipelined significand normalizer: shifts the leading one to bit SIG_W-1,
// adjusts the exponent, clamps to denormal on exponent underflow and flags zero/bad counts.
module fp_norm_shift #(
    parameter int SIG_W = 23,
    parameter int EXP_W = 8,
    parameter int LZC_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIG_W-1:0] in_sig,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [LZC_W-1:0] in_lzc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIG_W-1:0] out_sig,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_denorm,
    output logic             out_lzc_err
);

    localparam int CMP_W = (EXP_W > LZC_W) ? EXP_W : LZC_W;
    localparam logic [LZC_W-1:0] LZC_MAX = LZC_W'(SIG_W - 1);

    logic             s1_valid, s2_valid;
    logic             s1_adv, s2_adv;
    logic [SIG_W-1:0] s1_sig, s2_sig;
    logic [EXP_W-1:0] s1_exp, s2_exp;
    logic [LZC_W-1:0] s1_shamt;
    logic             s1_zero, s1_denorm, s1_err;
    logic             s2_zero, s2_denorm, s2_err;

    logic [LZC_W-1:0] lzc_c;
    logic [CMP_W-1:0] exp_x, lzc_x;
    logic             zero_d, denorm_d, err_d;
    logic [LZC_W-1:0] shamt_d;
    logic [EXP_W-1:0] exp_d;
    logic [SIG_W-1:0] sig_n;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Comparisons are done at a common width so neither field is truncated.
    always_comb begin
        lzc_c    = (in_lzc > LZC_MAX) ? LZC_MAX : in_lzc;
        exp_x    = CMP_W'(in_exp);
        lzc_x    = CMP_W'(lzc_c);
        zero_d   = (in_sig == '0);
        denorm_d = !zero_d && (exp_x <= lzc_x);
        shamt_d  = denorm_d ? LZC_W'(exp_x) : lzc_c;
        exp_d    = (zero_d || denorm_d) ? '0 : (in_exp - EXP_W'(lzc_x));
        err_d    = !zero_d && ((in_lzc > LZC_MAX) ||
                   ((in_sig >> (LZC_MAX - lzc_c)) != SIG_W'(1)));
    end

    always_comb begin
        sig_n = s1_zero ? '0 : (s1_sig << s1_shamt);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_sig    <= '0;
            s1_exp    <= '0;
            s1_shamt  <= '0;
            s1_zero   <= 1'b0;
            s1_denorm <= 1'b0;
            s1_err    <= 1'b0;
            s2_valid  <= 1'b0;
            s2_sig    <= '0;
            s2_exp    <= '0;
            s2_zero   <= 1'b0;
            s2_denorm <= 1'b0;
            s2_err    <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sig    <= sig_n;
                    s2_exp    <= s1_exp;
                    s2_zero   <= s1_zero;
                    s2_denorm <= s1_denorm;
                    s2_err    <= s1_err;
                end
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sig    <= in_sig;
                    s1_exp    <= exp_d;
                    s1_shamt  <= shamt_d;
                    s1_zero   <= zero_d;
                    s1_denorm <= denorm_d;
                    s1_err    <= err_d;
                end
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_sig     = s2_sig;
    assign out_exp     = s2_exp;
    assign out_zero    = s2_zero;
    assign out_denorm  = s2_denorm;
    assign out_lzc_err = s2_err;

endmodule
